// File: rtl/serdesphy_csr_bank_if.sv
// Register-access port between the I2C slave (master side) and the CSR bank (slave side).
interface serdesphy_csr_bank_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              bus_err;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, rvalid, bus_err
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, rvalid, bus_err
    );
endinterface

// File: rtl/serdesphy_csr_bank.sv
// SerDes PHY CSR bank: per-bit RW / RO / W1C / self-clearing pulse bits, write strobes and a
// maskable level interrupt.
module serdesphy_csr_bank #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter logic [NUM_REGS*DATA_W-1:0] RW_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] W1C_MASK = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] SC_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0,
    parameter int unsigned PULSE_LEN   = 4,
    parameter int unsigned IRQ_STS_IDX = 6,
    parameter int unsigned IRQ_EN_IDX  = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    serdesphy_csr_bank_if.slave          bus,
    output logic [NUM_REGS*DATA_W-1:0]   regs_q,
    output logic [NUM_REGS-1:0]          wr_strobe,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    output logic                         irq
);

    localparam int unsigned NB = NUM_REGS * DATA_W;
    // W1C takes precedence over RW; SC bits only exist where the bit is plain RW.
    localparam logic [NB-1:0] W1cBits   = W1C_MASK;
    localparam logic [NB-1:0] RwBits    = RW_MASK & ~W1C_MASK;
    localparam logic [NB-1:0] ScBits    = SC_MASK & RwBits;
    localparam logic [NB-1:0] StoreBits = RwBits | W1cBits;
    localparam logic [7:0]    PulseInit = 8'(PULSE_LEN - 1);

    logic [NB-1:0]       state_q, state_d;
    logic [7:0]          cnt_q [NB];
    logic [7:0]          cnt_d [NB];
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, bus_err_q, bus_err_d;
    logic [NUM_REGS-1:0] wr_sel, wr_strobe_q;
    logic                irq_q, irq_d;
    logic                in_range;
    logic [DATA_W-1:0]   rd_word;

    assign in_range = (32'(bus.addr) < NUM_REGS);

    // Stored bits come from flops; RO bits pass hw_status straight through.
    assign regs_q = (state_q & StoreBits) | (hw_status & ~StoreBits);

    always_comb begin
        wr_sel  = '0;
        rd_word = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (bus.addr == ADDR_W'(i)) begin
                wr_sel[i] = bus.wr_en;
                rd_word   = regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            for (int j = 0; j < int'(DATA_W); j++) begin
                int b;
                b = i * int'(DATA_W) + j;
                if (ScBits[b] && state_q[b]) begin
                    if (cnt_q[b] == 8'd0) state_d[b] = 1'b0;
                    else                  cnt_d[b]   = cnt_q[b] - 8'd1;
                end
                if (wr_sel[i]) begin
                    if (ScBits[b]) begin
                        state_d[b] = bus.wdata[j];
                        if (bus.wdata[j]) cnt_d[b] = PulseInit;
                    end else if (RwBits[b]) begin
                        state_d[b] = bus.wdata[j];
                    end else if (W1cBits[b] && bus.wdata[j]) begin
                        state_d[b] = 1'b0;
                    end
                end
                // A hardware set in the same cycle as a software clear must not be lost.
                if (W1cBits[b] && hw_set[b]) state_d[b] = 1'b1;
            end
        end
        state_d = state_d & StoreBits;
    end

    always_comb begin
        rdata_d   = rdata_q;
        bus_err_d = (bus.wr_en || bus.rd_en) && !in_range;
        if (bus.rd_en) rdata_d = in_range ? rd_word : '0;
        irq_d = |(regs_q[IRQ_STS_IDX*DATA_W +: DATA_W] & W1cBits[IRQ_STS_IDX*DATA_W +: DATA_W]
                  & regs_q[IRQ_EN_IDX*DATA_W +: DATA_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_VAL & RwBits & ~ScBits;
            for (int b = 0; b < int'(NB); b++) cnt_q[b] <= 8'd0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            wr_strobe_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= bus.rd_en;
            bus_err_q   <= bus_err_d;
            wr_strobe_q <= wr_sel;
            irq_q       <= irq_d;
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.bus_err = bus_err_q;
    assign wr_strobe   = wr_strobe_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_serdesphy_csr_bank.sv
// Directed bench for serdesphy_csr_bank: read data checked through an expected-value queue,
// side-band outputs checked inline.
module tb_serdesphy_csr_bank;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NB       = NUM_REGS * DATA_W;

    // reg0 RW with SC bit4, reg1 RW low nibble, reg2 RW, reg6 W1C, reg7 RW (irq enables)
    localparam logic [NB-1:0] RW_MASK  = 64'hFF00_0000_00FF_0FFF;
    localparam logic [NB-1:0] W1C_MASK = 64'h00FF_0000_0000_0000;
    localparam logic [NB-1:0] SC_MASK  = 64'h0000_0000_0000_0010;
    localparam logic [NB-1:0] RST_VAL  = 64'h0000_0000_003C_A500;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] regs_q;
    logic [NUM_REGS-1:0] wr_strobe;
    logic [NB-1:0] hw_status;
    logic [NB-1:0] hw_set;
    logic          irq;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    serdesphy_csr_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    serdesphy_csr_bank #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RW_MASK  (RW_MASK),
        .W1C_MASK (W1C_MASK),
        .SC_MASK  (SC_MASK),
        .RST_VAL  (RST_VAL),
        .PULSE_LEN(4),
        .IRQ_STS_IDX(6),
        .IRQ_EN_IDX (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .regs_q   (regs_q),
        .wr_strobe(wr_strobe),
        .hw_status(hw_status),
        .hw_set   (hw_set),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        exp_q.push_back(exp);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    // Scoreboard: every rvalid pops one expected read value.
    always @(negedge clk) begin
        if (bus.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 64'(bus.rvalid), 64'd0);
            end else begin
                check("rdata", 64'(bus.rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        hw_set    = '0;
        hw_status = 64'h0000_0000_5A00_A000;
        tick();
        do_write(4'd2, 8'hFF);  // dropped: reset still asserted
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_wr_strobe", 64'(wr_strobe), 64'd0);
        check("rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("rst_bus_err", 64'(bus.bus_err), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        rst = 1'b0;

        // 1: reset values
        do_read(4'd1, 8'hA5);
        check("rd_latency_rvalid", 64'(bus.rvalid), 64'd1);
        tick();
        check("rvalid_one_cycle", 64'(bus.rvalid), 64'd0);
        check("rdata_hold", 64'(bus.rdata), 64'hA5);
        do_read(4'd2, 8'h3C);

        // 2: mixed RW/RO register, write strobe, RO register
        do_write(4'd1, 8'hFF);
        check("wr_strobe_reg1", 64'(wr_strobe), 64'h02);
        tick();
        check("wr_strobe_clear", 64'(wr_strobe), 64'h00);
        do_read(4'd1, 8'hAF);
        hw_status[15:8] = 8'h50;
        #1;
        check("ro_live", 64'(regs_q[15:8]), 64'h5F);
        hw_status[15:8] = 8'hA0;
        do_write(4'd3, 8'hFF);
        check("wr_strobe_reg3", 64'(wr_strobe), 64'h08);
        do_read(4'd3, 8'h5A);

        // Simultaneous read and write to one address returns the old value
        bus.addr  = 4'd2;
        bus.wdata = 8'h99;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        exp_q.push_back(8'h3C);
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        do_read(4'd2, 8'h99);

        // 3: W1C sticky bits
        hw_set[50] = 1'b1;
        tick();
        hw_set[50] = 1'b0;
        do_read(4'd6, 8'h04);
        do_read(4'd6, 8'h04);
        hw_set[50] = 1'b1;
        do_write(4'd6, 8'h04);
        hw_set[50] = 1'b0;
        do_read(4'd6, 8'h04);
        do_write(4'd6, 8'h04);
        do_read(4'd6, 8'h00);

        // 4: interrupt
        do_write(4'd7, 8'h04);
        hw_set[50] = 1'b1;
        tick();
        hw_set[50] = 1'b0;
        check("irq_not_yet", 64'(irq), 64'd0);
        check("sticky_set", 64'(regs_q[55:48]), 64'h04);
        tick();
        check("irq_assert", 64'(irq), 64'd1);
        do_write(4'd7, 8'h00);
        check("irq_hold_one", 64'(irq), 64'd1);
        tick();
        check("irq_deassert", 64'(irq), 64'd0);

        // 5: self-clearing pulse bit
        do_write(4'd0, 8'h10);
        for (int k = 0; k < 4; k++) begin
            check("sc_high", 64'(regs_q[4]), 64'd1);
            tick();
        end
        check("sc_low_after4", 64'(regs_q[4]), 64'd0);
        do_write(4'd0, 8'h10);
        check("sc_ext_c0", 64'(regs_q[4]), 64'd1);
        tick();
        check("sc_ext_c1", 64'(regs_q[4]), 64'd1);
        do_write(4'd0, 8'h10);
        for (int k = 0; k < 4; k++) begin
            check("sc_ext_high", 64'(regs_q[4]), 64'd1);
            tick();
        end
        check("sc_ext_low", 64'(regs_q[4]), 64'd0);
        do_write(4'd0, 8'h10);
        do_write(4'd0, 8'h00);
        check("sc_write0", 64'(regs_q[4]), 64'd0);

        // 6: out-of-range accesses
        do_read(4'd15, 8'h00);
        check("oor_bus_err", 64'(bus.bus_err), 64'd1);
        check("oor_rvalid", 64'(bus.rvalid), 64'd1);
        tick();
        check("oor_bus_err_pulse", 64'(bus.bus_err), 64'd0);
        do_write(4'd10, 8'hFF);
        check("oor_wr_bus_err", 64'(bus.bus_err), 64'd1);
        check("oor_wr_strobe", 64'(wr_strobe), 64'd0);
        do_read(4'd2, 8'h99);

        // Reset during an active pulse with irq asserted
        do_write(4'd7, 8'h04);
        do_write(4'd0, 8'h10);
        check("pre_rst_irq", 64'(irq), 64'd1);
        check("pre_rst_sc", 64'(regs_q[4]), 64'd1);
        rst = 1'b1;
        tick();
        check("rst_sc_clear", 64'(regs_q[4]), 64'd0);
        check("rst_irq_clear", 64'(irq), 64'd0);
        check("rst_w1c_clear", 64'(regs_q[55:48]), 64'h00);
        check("rst_reg1", 64'(regs_q[15:8]), 64'hA5);
        rst = 1'b0;
        tick();
        tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serdesphy_csr_bank.md
Name: serdesphy_csr_bank

Overview:
Parametrised CSR register bank for the SerDes PHY. It replaces the fixed 8x8 register echo with per-bit access types: RW, RO (hardware status), W1C sticky event capture, and self-clearing pulse bits with a programmable pulse length. It also provides a maskable interrupt and per-register write strobes. It sits between the I2C slave's register-access port and the PHY control/status fabric.

Parameters:
NUM_REGS, 16, number of registers; addresses 0..NUM_REGS-1
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= NUM_REGS
DATA_W, 8, register width in bits
RW_MASK, all 0, NUM_REGS*DATA_W bits; 1 = bit is software read/write
W1C_MASK, all 0, NUM_REGS*DATA_W bits; 1 = sticky bit, set by hardware, cleared by writing 1
SC_MASK, all 0, NUM_REGS*DATA_W bits; 1 = self-clearing pulse bit; must be a subset of RW_MASK
RST_VAL, all 0, NUM_REGS*DATA_W bits; reset value of RW bits (W1C and SC bits reset to 0)
PULSE_LEN, 4, cycles an SC bit stays high after being written 1 (1..255)
IRQ_STS_IDX, 6, index of the register whose W1C bits feed the interrupt
IRQ_EN_IDX, 7, index of the RW register holding the per-bit interrupt enables

Ports:
clk  input  1  system clock (24 MHz)
rst  input  1  synchronous reset, active-high
wr_en  input  1  bus write request; one-cycle pulse
rd_en  input  1  bus read request; one-cycle pulse
addr  input  ADDR_W  register address
wdata  input  DATA_W  write data
rdata  output  DATA_W  read data; valid when rvalid=1
rvalid  output  1  read data valid; one-cycle pulse
bus_err  output  1  one-cycle pulse on access to address >= NUM_REGS
regs_q  output  NUM_REGS*DATA_W  current register contents, flattened; register i at [i*DATA_W +: DATA_W]
wr_strobe  output  NUM_REGS  one-hot pulse, bit i for an accepted write to register i
hw_status  input  NUM_REGS*DATA_W  live values for RO bits
hw_set  input  NUM_REGS*DATA_W  set pulses for W1C bits
irq  output  1  level interrupt

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, rst. While rst=1 at a clk edge:
  - RW bits load RST_VAL; W1C bits, SC bits and the SC counters clear.
  - rdata=0, rvalid=0, bus_err=0, wr_strobe=0, irq=0.
  - Any access in the same cycle is dropped.
- Bit classes:
  - RO = neither RW nor W1C. An RO bit in regs_q and rdata reflects hw_status combinationally.
  - A bit set in both RW_MASK and W1C_MASK is treated as W1C.
- Write (wr_en=1, addr<NUM_REGS), applied at the clk edge:
  - RW bits take wdata.
  - W1C bits with wdata=1 clear.
  - RO bits are ignored.
  - wr_strobe[addr] pulses in the next cycle.
- Read (rd_en=1, addr<NUM_REGS):
  - rdata = register value sampled at the request edge; rvalid=1 the next cycle. Latency is 1 cycle.
  - rdata holds its value until the next read.
  - A read has no side effects; W1C bits are not cleared by a read.
- Simultaneous wr_en and rd_en, same address: the read returns the pre-write value.
- Out-of-range address:
  - bus_err pulses the next cycle and no state changes.
  - A read also pulses rvalid, with rdata=0.
- W1C bits: set when hw_set=1.
  - hw_set=1 and a software clear in the same cycle: set wins, bit stays 1.
  - A W1C bit remains 1 until cleared.
- SC bits:
  - Writing 1 sets the bit and loads its counter with PULSE_LEN-1.
  - The bit stays 1 for exactly PULSE_LEN cycles, then clears itself.
  - Rewriting 1 while active reloads the counter, extending the pulse.
  - Writing 0 clears the bit immediately.
  - Each SC bit has its own 8-bit counter.
- Interrupt:
  - irq registered: irq(t+1) = |(W1C bits of IRQ_STS_IDX & regs_q[IRQ_EN_IDX]).
  - irq deasserts one cycle after the last enabled sticky bit clears or its enable is written 0.
- Back-to-back accesses every cycle are supported; there are no stalls.

Test Plan:
1. Reset with RST_VAL reg1=0xA5, then read addr 1 -> rdata=0xA5, rvalid 1 cycle after rd_en; irq=0, wr_strobe=0.
2. reg1 RW_MASK=0x0F: write 0xFF to addr 1, then read -> 0xA5 upper RO bits driven by hw_status=0xA0 read as 0xAF; wr_strobe=16'h0002 for one cycle.
3. W1C_MASK reg6=0xFF: pulse hw_set bit2 -> read 0x04; write 0x04 while hw_set bit2=1 in the same cycle -> still 0x04; write 0x04 with no set -> 0x00.
4. IRQ: reg7=0x04, hw_set reg6 bit2 -> irq=1 one cycle later; write reg7=0x00 -> irq=0 one cycle later.
5. SC bit reg0 bit4, PULSE_LEN=4: write 0x10 -> bit high exactly 4 cycles; rewrite at cycle 2 -> high for 6 cycles total.
6. Read addr 15 with NUM_REGS=8 -> rvalid=1, rdata=0x00, bus_err=1 for one cycle; assert rst mid-pulse -> all SC bits 0 the next cycle.
